// File: rtl/output_encoder_if.sv
// output_encoder_if: register-write bus for output_encoder
// Signals: WE write strobe, Addr register select, WData write data, RData combinational readback.
// The master drives the writes. The slave answers with RData.
interface output_encoder_if;
  logic        WE;
  logic [1:0]  Addr;
  logic [15:0] WData;
  logic [15:0] RData;
  modport master(output WE, Addr, WData, input RData);
  modport slave(input WE, Addr, WData, output RData);
endinterface

// File: rtl/output_encoder.sv
// output_encoder: four-digit hex seven-segment encoder with dp, blink, zero suppression and display enable
// Ports: Clock rising-edge clock; Reset asynchronous active-low; bus register write/readback (slave);
//        oct0..oct3 registered segment patterns (bit0..6 = a..g, bit7 = dp, active-high).
module output_encoder #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic              Clock,
  input  logic              Reset,
  output_encoder_if.slave   bus,
  output logic [7:0]        oct0,
  output logic [7:0]        oct1,
  output logic [7:0]        oct2,
  output logic [7:0]        oct3
);
  localparam logic [26:0] LAST = 27'(BLINK_DIV - 1);
  localparam logic [15:0][6:0] SEG = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [15:0]     value;
  logic [9:0]      ctrl;
  logic [26:0]     cnt;
  logic            phase;
  logic [3:0]      zero, sup, blank;
  logic [3:0][7:0] pat;
  // A digit is suppressed only while it and every digit above it are zero.
  // Digit 0 is never suppressed.
  assign sup[3] = ctrl[8] & zero[3];
  assign sup[2] = ctrl[8] & zero[3] & zero[2];
  assign sup[1] = ctrl[8] & zero[3] & zero[2] & zero[1];
  assign sup[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign zero[i]  = value[4*i +: 4] == 4'd0;
    assign blank[i] = !ctrl[9] || (ctrl[4+i] && phase);
    assign pat[i]   = blank[i] ? 8'h00 : {ctrl[i], sup[i] ? 7'h00 : SEG[value[4*i +: 4]]};
  end
  assign bus.RData = bus.Addr == 2'd0 ? value : bus.Addr == 2'd1 ? {6'd0, ctrl} : 16'd0;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      value <= '0;
      ctrl  <= 10'h200;
      cnt   <= '0;
      phase <= 1'b0;
      {oct3, oct2, oct1, oct0} <= '0;
    end else begin
      if (bus.WE && bus.Addr == 2'd0) value <= bus.WData;
      if (bus.WE && bus.Addr == 2'd1) ctrl <= bus.WData[9:0];
      cnt <= cnt == LAST ? '0 : cnt + 27'd1;
      if (cnt == LAST) phase <= ~phase;
      {oct3, oct2, oct1, oct0} <= pat;
    end
  end
endmodule

// File: tb/tb_output_encoder.sv
// tb_output_encoder: directed and random stimulus against a cycle-count reference model
module tb_output_encoder;
  localparam int DIV = 4;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] oct0, oct1, oct2, oct3;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] m_value = 16'h0000;
  logic [9:0]  m_ctrl = 10'h200;
  int          m_edges = 0;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  output_encoder_if bus();
  output_encoder #(.BLINK_DIV(DIV)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .oct0(oct0), .oct1(oct1), .oct2(oct2), .oct3(oct3)
  );
  always #5 Clock = ~Clock;

  function automatic logic [31:0] exp_oct(input logic [15:0] v, input logic [9:0] c, input int edges);
    logic [31:0] r;
    bit          ph, sup, blank;
    r  = '0;
    ph = ((edges / DIV) % 2) == 1;
    for (int n = 0; n < 4; n++) begin
      sup   = c[8] && n > 0 && (v >> (4 * n)) == 16'd0;
      blank = !c[9] || (c[4+n] && ph);
      if (!blank) r[8*n +: 8] = {c[n], sup ? 7'h00 : seg_tab[(v >> (4 * n)) & 16'hF]};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rdata(input logic [1:0] a);
    return a == 2'd0 ? m_value : a == 2'd1 ? {6'd0, m_ctrl} : 16'd0;
  endfunction

  task automatic cyc(input logic we, input logic [1:0] a, input logic [15:0] d);
    logic [31:0] e;
    bus.WE = we;
    bus.Addr = a;
    bus.WData = d;
    e = exp_oct(m_value, m_ctrl, m_edges);
    @(posedge Clock);
    if (we && a == 2'd0) m_value = d;
    if (we && a == 2'd1) m_ctrl = d[9:0];
    m_edges++;
    #1;
    chk("oct", {oct3, oct2, oct1, oct0}, e);
    chk("rdata", {16'd0, bus.RData}, {16'd0, exp_rdata(a)});
    bus.WE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    bus.Addr = a;
    #1;
    chk(tag, {16'd0, bus.RData}, {16'd0, exp});
  endtask

  initial begin
    bus.WE = 1'b0;
    bus.Addr = 2'd0;
    bus.WData = 16'h0000;
    #2;
    chk("reset_oct", {oct3, oct2, oct1, oct0}, 32'h0);
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_oct_clocked", {oct3, oct2, oct1, oct0}, 32'h0);
    rd("reset_value", 2'd0, 16'h0000);
    rd("reset_ctrl", 2'd1, 16'h0200);
    Reset = 1'b1;
    cyc(1'b0, 2'd0, 16'h0);
    chk("first_edge", {oct3, oct2, oct1, oct0}, 32'h3F3F3F3F);
    cyc(1'b0, 2'd0, 16'h0);
    cyc(1'b1, 2'd0, 16'hA5C1);
    cyc(1'b1, 2'd1, 16'h0205);
    chk("hex_nodp", {oct3, oct2, oct1, oct0}, 32'h776D3906);
    cyc(1'b0, 2'd1, 16'h0);
    chk("hex_dp", {oct3, oct2, oct1, oct0}, 32'h77ED3986);
    rd("ctrl_read", 2'd1, 16'h0205);
    cyc(1'b1, 2'd1, 16'h0300);
    cyc(1'b1, 2'd0, 16'h0070);
    cyc(1'b0, 2'd0, 16'h0);
    chk("lz_0070", {oct3, oct2, oct1, oct0}, 32'h0000073F);
    cyc(1'b1, 2'd0, 16'h0000);
    cyc(1'b0, 2'd0, 16'h0);
    chk("lz_0000", {oct3, oct2, oct1, oct0}, 32'h0000003F);
    cyc(1'b1, 2'd1, 16'h0210);
    cyc(1'b1, 2'd0, 16'h0008);
    for (int k = 0; k < 16; k++) cyc(1'b0, 2'd0, 16'h0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 2'd0, 16'(k + 5));
    cyc(1'b1, 2'd0, 16'hF00D);
    cyc(1'b1, 2'd1, 16'h0000);
    cyc(1'b0, 2'd0, 16'h0);
    chk("display_off", {oct3, oct2, oct1, oct0}, 32'h0);
    rd("value_while_off", 2'd0, 16'hF00D);
    cyc(1'b1, 2'd3, 16'hFFFF);
    cyc(1'b1, 2'd2, 16'hFFFF);
    rd("value_after_reserved", 2'd0, 16'hF00D);
    rd("ctrl_after_reserved", 2'd1, 16'h0000);
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
    cyc(1'b1, 2'd1, 16'h02F0);
    cyc(1'b1, 2'd0, 16'h9999);
    for (int k = 0; k < 5; k++) cyc(1'b0, 2'd0, 16'h0);
    bus.WE = 1'b1;
    bus.Addr = 2'd0;
    bus.WData = 16'h1234;
    #2;
    Reset = 1'b0;
    #1;
    chk("midreset_oct", {oct3, oct2, oct1, oct0}, 32'h0);
    chk("midreset_value", {16'd0, bus.RData}, 32'h0);
    @(posedge Clock);
    #1;
    chk("midreset_hold_oct", {oct3, oct2, oct1, oct0}, 32'h0);
    chk("midreset_hold_value", {16'd0, bus.RData}, 32'h0);
    bus.WE = 1'b0;
    rd("midreset_ctrl", 2'd1, 16'h0200);
    Reset = 1'b1;
    m_value = 16'h0000;
    m_ctrl = 10'h200;
    m_edges = 0;
    cyc(1'b0, 2'd0, 16'h0);
    chk("rerelease_edge", {oct3, oct2, oct1, oct0}, 32'h3F3F3F3F);
    for (int k = 0; k < 6; k++) cyc(1'b0, 2'd1, 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
